// File: rtl/lcd_hd44780_ctrl.sv
// Purpose: HD44780 16x2 panel driver (8-bit, write-only) with autonomous power-on init; optional LCD_AUTO_WRAP_EN line wrap.
// Latency: a request is accepted on the edge where rdy_o && enb_i; RS/DATA are driven the next cycle and E rises T_SETUP cycles later.
// Backpressure: rdy_o stays low while busy; a request is not re-armed until DONE sees enb_i low.
module lcd_hd44780_ctrl #(
    parameter int T_POWERUP = 1500000,
    parameter int T_SETUP   = 4,
    parameter int T_PULSE   = 25,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 4000,
    parameter int T_LONG    = 164000,
    parameter int T_INIT1   = 410000,
    parameter int T_INIT2   = 10000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic [1:0] ops_i,
    input  logic       enb_i,
    output logic       rdy_o,
    output logic       lcd_rs_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_data_o
);

    typedef enum logic [2:0] {
        S_POWERUP, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_DONE
    } state_t;

    // The counter runs up from 0 and a state ends when it reaches duration-1.
    localparam logic [20:0] C_POWERUP = 21'(T_POWERUP - 1);
    localparam logic [20:0] C_SETUP   = 21'(T_SETUP - 1);
    localparam logic [20:0] C_PULSE   = 21'(T_PULSE - 1);
    localparam logic [20:0] C_HOLD    = 21'(T_HOLD - 1);
    localparam logic [20:0] C_EXEC    = 21'(T_EXEC - 1);
    localparam logic [20:0] C_LONG    = 21'(T_LONG - 1);
    localparam logic [20:0] C_INIT1   = 21'(T_INIT1 - 1);
    localparam logic [20:0] C_INIT2   = 21'(T_INIT2 - 1);

    state_t      state_q;
    logic [20:0] cnt_q;
    logic [20:0] wait_q;      // WAIT length for the write in flight
    logic [2:0]  idx_q;       // next init table entry
    logic        init_q;      // write in flight belongs to the init sequence
    logic        rdy_q;
    logic        e_q;
    logic        rs_q;
    logic [7:0]  dat_q;

    logic [7:0]  init_dat;
    logic [20:0] init_wait;
    logic        usr_rs;
    logic [7:0]  usr_dat;
    logic [20:0] usr_wait;

    // Power-on init table: byte to write and the wait that follows it.
    always_comb begin
        init_dat  = 8'h06;
        init_wait = C_EXEC;
        case (idx_q)
            3'd0:    begin init_dat = 8'h30; init_wait = C_INIT1; end
            3'd1:    begin init_dat = 8'h30; init_wait = C_INIT2; end
            3'd2:    begin init_dat = 8'h30; init_wait = C_EXEC;  end
            3'd3:    begin init_dat = 8'h38; init_wait = C_EXEC;  end
            3'd4:    begin init_dat = 8'h0C; init_wait = C_EXEC;  end
            3'd5:    begin init_dat = 8'h01; init_wait = C_LONG;  end
            default: begin init_dat = 8'h06; init_wait = C_EXEC;  end
        endcase
    end

    // Translate a user request into the panel byte; clear/home ignore data_i.
    always_comb begin
        usr_dat = data_i;
        case (ops_i)
            2'b10:   usr_dat = 8'h01;
            2'b11:   usr_dat = 8'h02;
            default: usr_dat = data_i;
        endcase
    end

    assign usr_rs   = (ops_i == 2'b01);
    assign usr_wait = ops_i[1] ? C_LONG : C_EXEC;

`ifdef LCD_AUTO_WRAP_EN
    logic [6:0] cur_q;        // DDRAM address the panel cursor points at
    logic       pend_q;       // character still owed after an inserted line jump
    logic [7:0] pend_dat_q;
    logic [6:0] cur_nxt;
    logic       wrap_hit;
    logic [7:0] wrap_cmd;

    assign wrap_hit = (ops_i == 2'b01) && ((cur_q == 7'h10) || (cur_q == 7'h50));
    assign wrap_cmd = (cur_q == 7'h10) ? 8'hC0 : 8'h80;

    // Cursor position after the accepted request (line jump already folded in).
    always_comb begin
        cur_nxt = cur_q;
        case (ops_i)
            2'b00: if (data_i[7]) cur_nxt = data_i[6:0];
            2'b01: begin
                if (cur_q == 7'h10)      cur_nxt = 7'h41;
                else if (cur_q == 7'h50) cur_nxt = 7'h01;
                else                     cur_nxt = cur_q + 7'd1;
            end
            default: cur_nxt = 7'h00;
        endcase
    end
`endif

    // Main controller: init sequencing, request accept and the shared write engine.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_POWERUP;
            cnt_q   <= '0;
            wait_q  <= '0;
            idx_q   <= '0;
            init_q  <= 1'b0;
            rdy_q   <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            dat_q   <= '0;
`ifdef LCD_AUTO_WRAP_EN
            cur_q      <= '0;
            pend_q     <= 1'b0;
            pend_dat_q <= '0;
`endif
        end else if (rst_i) begin
            state_q <= S_POWERUP;
            cnt_q   <= '0;
            wait_q  <= '0;
            idx_q   <= '0;
            init_q  <= 1'b0;
            rdy_q   <= 1'b0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            dat_q   <= '0;
`ifdef LCD_AUTO_WRAP_EN
            cur_q      <= '0;
            pend_q     <= 1'b0;
            pend_dat_q <= '0;
`endif
        end else begin
            case (state_q)
                S_POWERUP: begin
                    if (cnt_q == C_POWERUP) begin
                        state_q <= S_INIT;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 21'd1;
                    end
                end
                S_INIT: begin
                    if (idx_q == 3'd7) begin
                        state_q <= S_IDLE;
                        rdy_q   <= 1'b1;
                        init_q  <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
                        cur_q   <= '0;
`endif
                    end else begin
                        state_q <= S_SETUP;
                        cnt_q   <= '0;
                        rs_q    <= 1'b0;
                        dat_q   <= init_dat;
                        wait_q  <= init_wait;
                        idx_q   <= idx_q + 3'd1;
                        init_q  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (enb_i) begin
                        state_q <= S_SETUP;
                        cnt_q   <= '0;
                        rdy_q   <= 1'b0;
                        init_q  <= 1'b0;
`ifdef LCD_AUTO_WRAP_EN
                        cur_q   <= cur_nxt;
                        if (wrap_hit) begin
                            rs_q       <= 1'b0;
                            dat_q      <= wrap_cmd;
                            wait_q     <= C_EXEC;
                            pend_q     <= 1'b1;
                            pend_dat_q <= data_i;
                        end else begin
                            rs_q   <= usr_rs;
                            dat_q  <= usr_dat;
                            wait_q <= usr_wait;
                        end
`else
                        rs_q    <= usr_rs;
                        dat_q   <= usr_dat;
                        wait_q  <= usr_wait;
`endif
                    end
                end
                S_SETUP: begin
                    if (cnt_q == C_SETUP) begin
                        state_q <= S_PULSE;
                        cnt_q   <= '0;
                        e_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 21'd1;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == C_PULSE) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        e_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 21'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == C_HOLD) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 21'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == wait_q) begin
                        cnt_q <= '0;
                        if (init_q) begin
                            state_q <= S_INIT;
`ifdef LCD_AUTO_WRAP_EN
                        end else if (pend_q) begin
                            // Line jump done; now write the character that triggered it.
                            state_q <= S_SETUP;
                            rs_q    <= 1'b1;
                            dat_q   <= pend_dat_q;
                            wait_q  <= C_EXEC;
                            pend_q  <= 1'b0;
`endif
                        end else begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 21'd1;
                    end
                end
                S_DONE: begin
                    // A held strobe must not launch a second write.
                    if (!enb_i) begin
                        state_q <= S_IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_POWERUP;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rdy_o      = rdy_q;
    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = dat_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Purpose: self-checking bench for lcd_hd44780_ctrl (table vectors, random requests vs. reference model, reset corners).
// Latency: timing is measured in clock edges from the accepting edge; outputs sampled on the falling edge.
// Backpressure: requests wait for rdy_o; enb_i dropped right after accept unless a hold is being tested.
module tb_lcd_hd44780_ctrl;

    localparam int T_POWERUP = 20;
    localparam int T_SETUP   = 2;
    localparam int T_PULSE   = 3;
    localparam int T_HOLD    = 1;
    localparam int T_EXEC    = 10;
    localparam int T_LONG    = 40;
    localparam int T_INIT1   = 15;
    localparam int T_INIT2   = 5;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       rst_i;
    logic [7:0] data_i;
    logic [1:0] ops_i;
    logic       enb_i;
    logic       rdy_o;
    logic       lcd_rs_o;
    logic       lcd_e_o;
    logic [7:0] lcd_data_o;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int mcur = 0;   // model cursor, as a DDRAM address

    typedef struct { logic rs; logic [7:0] dat; int rise; int width; } pulse_t;
    typedef struct { logic rs; logic [7:0] dat; } wr_t;
    typedef struct { logic [1:0] op; logic [7:0] dat; int exp_rs; int exp_dat; int exp_busy; } vec_t;

    pulse_t seen[$];
    wr_t    expq[$];
    vec_t   tbl [6];

    logic [7:0] init_seq [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         init_w   [7] = '{T_INIT1, T_INIT2, T_EXEC, T_EXEC, T_EXEC, T_LONG, T_EXEC};

    lcd_hd44780_ctrl #(
        .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
        .T_EXEC(T_EXEC), .T_LONG(T_LONG), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rst_i(rst_i), .data_i(data_i), .ops_i(ops_i),
        .enb_i(enb_i), .rdy_o(rdy_o), .lcd_rs_o(lcd_rs_o), .lcd_e_o(lcd_e_o), .lcd_data_o(lcd_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // E pulse monitor: logs every pulse and checks RS/DATA setup and stability.
    logic       e_prev = 1'b0;
    logic [8:0] rsd_prev = '0;
    int         stab = 0;
    always @(negedge clk_i) begin
        logic [8:0] rsd;
        rsd = {lcd_rs_o, lcd_data_o};
        if (lcd_e_o && !e_prev) begin
            nvec++;
            if (stab < T_SETUP || rsd != rsd_prev) begin
                nerr++;
                $display("FAIL setup: RS/DATA stable %0d cycles before E, expected at least %0d", stab, T_SETUP);
            end
            seen.push_back('{lcd_rs_o, lcd_data_o, cyc, 0});
        end else if (lcd_e_o && e_prev && rsd != rsd_prev) begin
            nvec++;
            nerr++;
            $display("FAIL pulse_stable: RS/DATA changed from 0x%0h to 0x%0h while E high", rsd_prev, rsd);
        end else if (!lcd_e_o && e_prev && seen.size() > 0) begin
            seen[seen.size()-1].width = cyc - seen[seen.size()-1].rise;
        end
        if (rsd != rsd_prev) stab = 1;
        else                 stab = stab + 1;
        rsd_prev = rsd;
        e_prev   = lcd_e_o;
    end

    task automatic wait_rdy(input string name);
        int t = 0;
        while (rdy_o !== 1'b1 && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        if (rdy_o !== 1'b1) timeout(name);
    endtask

    // Reference model: panel writes a request produces and its accept-to-ready time.
    task automatic model_req(input logic [1:0] op, input logic [7:0] d, output int busy);
        expq.delete();
        busy = 1;   // one cycle in DONE before ready returns
`ifdef LCD_AUTO_WRAP_EN
        if (op == 2'b01 && (mcur == 'h10 || mcur == 'h50)) begin
            expq.push_back('{1'b0, (mcur == 'h10) ? 8'hC0 : 8'h80});
            busy += T_SETUP + T_PULSE + T_HOLD + T_EXEC;
            mcur = (mcur == 'h10) ? 'h40 : 'h00;
        end
`endif
        case (op)
            2'b00:   expq.push_back('{1'b0, d});
            2'b01:   expq.push_back('{1'b1, d});
            2'b10:   expq.push_back('{1'b0, 8'h01});
            default: expq.push_back('{1'b0, 8'h02});
        endcase
        busy += T_SETUP + T_PULSE + T_HOLD + (op[1] ? T_LONG : T_EXEC);
        if (op[1])                   mcur = 0;
        else if (op == 2'b00 && d[7]) mcur = int'(d[6:0]);
        else if (op == 2'b01)         mcur = (mcur + 1) % 128;
    endtask

    // Issue one request; k is the sample right after the accepting edge.
    task automatic req(input logic [1:0] op, input logic [7:0] d, input int hold,
                       output int k, output int m_rs, output int m_dat, output int m_rdy,
                       output int hi, output int busy);
        int t;
        wait_rdy("req_ready");
        seen.delete();
        ops_i  = op;
        data_i = d;
        enb_i  = 1'b1;
        @(negedge clk_i);
        k     = cyc;
        m_rs  = int'(lcd_rs_o);
        m_dat = int'(lcd_data_o);
        m_rdy = int'(rdy_o);
        hi    = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            if (rdy_o) hi++;
        end
        enb_i  = 1'b0;
        ops_i  = 2'($urandom);
        data_i = 8'($urandom);
        t = 0;
        while (rdy_o !== 1'b1 && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        if (rdy_o !== 1'b1) timeout("req_done");
        busy = cyc - k;
    endtask

    task automatic check_req(input logic [1:0] op, input logic [7:0] d);
        int eb, k, rs, dt, rd, hi, busy, n;
        model_req(op, d, eb);
        req(op, d, 0, k, rs, dt, rd, hi, busy);
        chk("busy_cycles", busy, eb);
        chk("pulse_count", seen.size(), expq.size());
        chk("rs_after_accept", rs, int'(expq[0].rs));
        chk("data_after_accept", dt, int'(expq[0].dat));
        chk("rdy_after_accept", rd, 0);
        n = (seen.size() < expq.size()) ? seen.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk("pulse_rs", int'(seen[i].rs), int'(expq[i].rs));
            chk("pulse_data", int'(seen[i].dat), int'(expq[i].dat));
            chk("pulse_width", seen[i].width, T_PULSE);
        end
        if (seen.size() > 0) chk("e_rise_offset", seen[0].rise - k, T_SETUP);
    endtask

    // Init replay check; r is the sample after the last edge that held the design in reset.
    task automatic check_init(input int r);
        int exp_t = T_POWERUP + 1;
        for (int i = 0; i < 7; i++) exp_t += 1 + T_SETUP + T_PULSE + T_HOLD + init_w[i];
        wait_rdy("init_done");
        chk("init_rdy_time", cyc - r, exp_t);
        chk("init_pulses", seen.size(), 7);
        for (int i = 0; i < 7 && i < seen.size(); i++) begin
            chk("init_data", int'(seen[i].dat), int'(init_seq[i]));
            chk("init_rs", int'(seen[i].rs), 0);
            chk("init_width", seen[i].width, T_PULSE);
        end
        mcur = 0;
    endtask

    initial begin
        int r, t, k, rs, dt, rd, hi, busy, eb;
        logic [1:0] rop;
        logic [7:0] rdat;

        tbl[0] = '{2'b01, 8'h48, 1, 'h48, 17};
        tbl[1] = '{2'b10, 8'hA5, 0, 'h01, 47};
        tbl[2] = '{2'b11, 8'h3C, 0, 'h02, 47};
        tbl[3] = '{2'b00, 8'h0F, 0, 'h0F, 17};
        tbl[4] = '{2'b01, 8'h41, 1, 'h41, 17};
        tbl[5] = '{2'b00, 8'h80, 0, 'h80, 17};

        rst_ni = 1'b0;
        rst_i  = 1'b0;
        enb_i  = 1'b0;
        ops_i  = 2'b00;
        data_i = 8'h00;
        repeat (3) @(negedge clk_i);
        chk("reset_rdy", int'(rdy_o), 0);
        chk("reset_e", int'(lcd_e_o), 0);
        chk("reset_rs", int'(lcd_rs_o), 0);
        chk("reset_data", int'(lcd_data_o), 0);

        // Power-on init sequence
        seen.delete();
        rst_ni = 1'b1;
        r = cyc;
        check_init(r);

        // Table-driven requests
        for (int i = 0; i < 6; i++) begin
            model_req(tbl[i].op, tbl[i].dat, eb);
            req(tbl[i].op, tbl[i].dat, 0, k, rs, dt, rd, hi, busy);
            chk("tbl_rs", rs, tbl[i].exp_rs);
            chk("tbl_data", dt, tbl[i].exp_dat);
            chk("tbl_rdy", rd, 0);
            chk("tbl_busy", busy, tbl[i].exp_busy);
            chk("tbl_pulses", seen.size(), 1);
            if (seen.size() > 0) chk("tbl_rise", seen[0].rise - k, T_SETUP);
        end

        // Strobe held 100 cycles: one write, ready one cycle after release
        model_req(2'b01, 8'h4C, eb);
        req(2'b01, 8'h4C, 100, k, rs, dt, rd, hi, busy);
        chk("hold_pulses", seen.size(), 1);
        chk("hold_rdy_high", hi, 0);
        chk("hold_release", busy, 100 + 1);

        // Random requests against the model
        for (int i = 0; i < 30; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rdat = 8'($urandom);
            check_req(rop, rdat);
        end

        // Line wrap: home, 16 characters, then the 17th
        check_req(2'b11, 8'h00);
        for (int i = 0; i < 16; i++) check_req(2'b01, 8'(8'h41 + i));
        check_req(2'b01, 8'h51);
`ifdef LCD_AUTO_WRAP_EN
        chk("wrap_pulses", seen.size(), 2);
        if (seen.size() > 1) begin
            chk("wrap_cmd", int'(seen[0].dat), 'hC0);
            chk("wrap_cmd_rs", int'(seen[0].rs), 0);
            chk("wrap_char", int'(seen[1].dat), 'h51);
        end
`else
        chk("nowrap_pulses", seen.size(), 1);
`endif
        for (int i = 0; i < 16; i++) check_req(2'b01, 8'(8'h61 + i));

        // Soft reset while E is high
        wait_rdy("rsti_ready");
        ops_i  = 2'b01;
        data_i = 8'h5A;
        enb_i  = 1'b1;
        @(negedge clk_i);
        enb_i = 1'b0;
        t = 0;
        while (!lcd_e_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (!lcd_e_o) timeout("rsti_wait_e");
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        r = cyc;
        seen.delete();
        chk("rsti_e", int'(lcd_e_o), 0);
        chk("rsti_rdy", int'(rdy_o), 0);
        check_init(r);

        // Hard reset in the middle of a long WAIT
        wait_rdy("rstn_ready");
        ops_i = 2'b10;
        enb_i = 1'b1;
        @(negedge clk_i);
        enb_i = 1'b0;
        t = 0;
        while (!lcd_e_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        t = 0;
        while (lcd_e_o && t < 100) begin
            @(negedge clk_i);
            t++;
        end
        if (lcd_e_o) timeout("rstn_wait_fall");
        repeat (3) @(negedge clk_i);
        chk("pre_rstn_data", int'(lcd_data_o), 'h01);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rdy", int'(rdy_o), 0);
        chk("async_e", int'(lcd_e_o), 0);
        chk("async_rs", int'(lcd_rs_o), 0);
        chk("async_data", int'(lcd_data_o), 0);
        @(negedge clk_i);
        seen.delete();
        rst_ni = 1'b1;
        r = cyc;
        check_init(r);
        check_req(2'b01, 8'h21);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
